// File: rtl/dcache_assoc.sv
// rtl/dcache_assoc.sv - 2-way set-associative data cache; write-through by default, write-back when DCACHE_WRITE_BACK_EN is defined
module dcache_assoc #(
    parameter int SETS = 4,
    parameter int WAYS = 2
) (
    input  logic         clk,
    input  logic         proc_reset,
    input  logic         proc_read,
    input  logic         proc_write,
    input  logic [29:0]  proc_addr,
    input  logic [31:0]  proc_wdata,
    output logic         proc_stall,
    output logic [31:0]  proc_rdata,
    output logic         mem_read,
    output logic         mem_write,
    output logic [27:0]  mem_addr,
    output logic [127:0] mem_wdata,
    input  logic [127:0] mem_rdata,
    input  logic         mem_ready
);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 28 - IDX_W;

    if (WAYS != 2) begin : g_bad_ways
        $error("dcache_assoc: WAYS must be 2");
    end
    if (SETS < 2 || SETS > 256 || (SETS & (SETS - 1)) != 0) begin : g_bad_sets
        $error("dcache_assoc: SETS must be a power of two in 2..256");
    end

    typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE, WRITETHRU} state_t;

    state_t           state_q, state_d;
    logic             way_q, way_d;
    logic [127:0]     data_q  [2][SETS];
    logic [TAG_W-1:0] tag_q   [2][SETS];
    logic [SETS-1:0]  valid_q [2];
    logic [SETS-1:0]  lru_q;
`ifdef DCACHE_WRITE_BACK_EN
    logic [SETS-1:0]  dirty_q [2];
    logic             line_dirty;
`endif

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic [1:0]       word;
    logic [1:0]       hit_w;
    logic             hit, hit_way, victim;
    logic             line_we, fill_en, touch, line_way;
    logic [127:0]     line_wdata;

    function automatic logic [31:0] pick_word(input logic [127:0] line, input logic [1:0] w);
        pick_word = line[{w, 5'd0} +: 32];
    endfunction

    function automatic logic [127:0] merge_word(input logic [127:0] line, input logic [1:0] w,
                                                input logic [31:0] d);
        merge_word = line;
        merge_word[{w, 5'd0} +: 32] = d;
    endfunction

    assign idx  = proc_addr[IDX_W+1:2];
    assign tag  = proc_addr[29:IDX_W+2];
    assign word = proc_addr[1:0];

    assign hit_w[0] = valid_q[0][idx] && (tag_q[0][idx] == tag);
    assign hit_w[1] = valid_q[1][idx] && (tag_q[1][idx] == tag);
    assign hit      = |hit_w;
    assign hit_way  = hit_w[1];
    // Fill empty ways first (way 0 before way 1); only a full set consults LRU.
    assign victim   = !valid_q[0][idx] ? 1'b0 : (!valid_q[1][idx] ? 1'b1 : lru_q[idx]);

    always_comb begin
        state_d    = state_q;
        way_d      = way_q;
        proc_stall = 1'b0;
        proc_rdata = '0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        line_we    = 1'b0;
        fill_en    = 1'b0;
        touch      = 1'b0;
        line_way   = way_q;
        line_wdata = mem_rdata;
`ifdef DCACHE_WRITE_BACK_EN
        line_dirty = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (proc_read || proc_write) begin
                    if (hit) begin
                        touch    = 1'b1;
                        line_way = hit_way;
                        way_d    = hit_way;
                        if (proc_write) begin
                            line_we    = 1'b1;
                            line_wdata = merge_word(data_q[hit_way][idx], word, proc_wdata);
`ifdef DCACHE_WRITE_BACK_EN
                            line_dirty = 1'b1;
`else
                            proc_stall = 1'b1;
                            state_d    = WRITETHRU;
`endif
                        end else begin
                            proc_rdata = pick_word(data_q[hit_way][idx], word);
                        end
                    end else begin
                        proc_stall = 1'b1;
                        way_d      = victim;
`ifdef DCACHE_WRITE_BACK_EN
                        if (valid_q[victim][idx] && dirty_q[victim][idx]) state_d = WRITEBACK;
                        else state_d = ALLOCATE;
`else
                        state_d = ALLOCATE;
`endif
                    end
                end
            end
            WRITEBACK: begin
                proc_stall = 1'b1;
                mem_write  = 1'b1;
                mem_addr   = {tag_q[way_q][idx], idx};
                mem_wdata  = data_q[way_q][idx];
                if (mem_ready) state_d = ALLOCATE;
            end
            ALLOCATE: begin
                proc_stall = 1'b1;
                mem_read   = 1'b1;
                mem_addr   = proc_addr[29:2];
                if (mem_ready) begin
                    line_we = 1'b1;
                    fill_en = 1'b1;
                    touch   = 1'b1;
                    if (proc_write) begin
                        line_wdata = merge_word(mem_rdata, word, proc_wdata);
`ifdef DCACHE_WRITE_BACK_EN
                        line_dirty = 1'b1;
                        proc_stall = 1'b0;
                        state_d    = IDLE;
`else
                        state_d    = WRITETHRU;
`endif
                    end else begin
                        proc_stall = 1'b0;
                        proc_rdata = pick_word(mem_rdata, word);
                        state_d    = IDLE;
                    end
                end
            end
            WRITETHRU: begin
                // The cached line already holds the merged word; push the whole line out.
                proc_stall = 1'b1;
                mem_write  = 1'b1;
                mem_addr   = proc_addr[29:2];
                mem_wdata  = data_q[way_q][idx];
                if (mem_ready) begin
                    proc_stall = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (proc_reset) begin
            state_q <= IDLE;
            way_q   <= 1'b0;
            lru_q   <= '0;
            for (int w = 0; w < 2; w++) begin
                valid_q[w] <= '0;
`ifdef DCACHE_WRITE_BACK_EN
                dirty_q[w] <= '0;
`endif
                for (int s = 0; s < SETS; s++) begin
                    data_q[w][s] <= '0;
                    tag_q[w][s]  <= '0;
                end
            end
        end else begin
            state_q <= state_d;
            way_q   <= way_d;
            if (line_we) data_q[line_way][idx] <= line_wdata;
            if (fill_en) begin
                tag_q[line_way][idx]   <= tag;
                valid_q[line_way][idx] <= 1'b1;
            end
            if (touch) lru_q[idx] <= ~line_way;
`ifdef DCACHE_WRITE_BACK_EN
            if (line_we) dirty_q[line_way][idx] <= line_dirty;
`endif
        end
    end
endmodule

// File: tb/tb_dcache_assoc.sv
// tb/tb_dcache_assoc.sv - scoreboard bench for dcache_assoc (SETS=4)
module tb_dcache_assoc;
    localparam int MEM_LAT = 1;

    logic         clk = 1'b0;
    logic         proc_reset, proc_read, proc_write;
    logic [29:0]  proc_addr;
    logic [31:0]  proc_wdata;
    logic         proc_stall;
    logic [31:0]  proc_rdata;
    logic         mem_read, mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata, mem_rdata;
    logic         mem_ready, resp_ready, spur_ready;

    assign mem_ready = resp_ready | spur_ready;

    always #5 clk = ~clk;

    dcache_assoc #(.SETS(4), .WAYS(2)) dut (
        .clk        (clk),
        .proc_reset (proc_reset),
        .proc_read  (proc_read),
        .proc_write (proc_write),
        .proc_addr  (proc_addr),
        .proc_wdata (proc_wdata),
        .proc_stall (proc_stall),
        .proc_rdata (proc_rdata),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready)
    );

    typedef struct {logic is_read; logic [31:0] rdata; int lat;} cpu_exp_t;
    typedef struct {logic wr; logic [27:0] addr; logic [127:0] wdata;} mem_exp_t;

    cpu_exp_t cpu_q[$];
    mem_exp_t mem_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   issue_cyc = 0;
    logic hold_ready = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Memory image: line 1 is {D,C,B,A}; any other line holds 0x1000_0000 | addr<<4 | word.
    function automatic logic [127:0] line_data(input logic [27:0] a);
        logic [31:0] base;
        if (a == 28'h1) return {32'hD, 32'hC, 32'hB, 32'hA};
        base = 32'h1000_0000 | {a, 4'h0};
        return {base | 32'd3, base | 32'd2, base | 32'd1, base};
    endfunction

    initial begin
        int wait_c = 0;
        resp_ready = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(posedge clk); #1;
            if (resp_ready) begin
                resp_ready = 1'b0;
                wait_c = 0;
            end
            if ((mem_read || mem_write) && !hold_ready && !proc_reset) begin
                if (wait_c >= MEM_LAT) begin
                    resp_ready = 1'b1;
                    mem_rdata  = line_data(mem_addr);
                end else begin
                    wait_c++;
                end
            end else begin
                wait_c = 0;
            end
        end
    end

    always @(negedge clk) begin
        cpu_exp_t e;
        mem_exp_t m;
        check("mem_rw_exclusive", 128'(mem_read && mem_write), 128'd0);
        if (!mem_read && !mem_write)
            check("mem_idle_zero", 128'((|mem_addr) || (|mem_wdata)), 128'd0);
        if ((proc_read || proc_write) && !proc_stall) begin
            if (cpu_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL cpu_unexpected: actual completion at addr %0h required none", proc_addr);
            end else begin
                e = cpu_q.pop_front();
                check("cpu_latency", 128'(cyc - issue_cyc), 128'(e.lat));
                if (e.is_read) check("cpu_rdata", 128'(proc_rdata), 128'(e.rdata));
            end
        end
        if (mem_ready && (mem_read || mem_write)) begin
            if (mem_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL mem_unexpected: actual op at %0h required none", mem_addr);
            end else begin
                m = mem_q.pop_front();
                check("mem_is_write", 128'(mem_write), 128'(m.wr));
                check("mem_addr", 128'(mem_addr), 128'(m.addr));
                if (m.wr) check("mem_wdata", mem_wdata, m.wdata);
            end
        end
    end

    task automatic expect_mem(input logic wr, input logic [27:0] a, input logic [127:0] wd);
        mem_exp_t m;
        m.wr = wr; m.addr = a; m.wdata = wd;
        mem_q.push_back(m);
    endtask

    task automatic access(input logic rd, input logic wr, input logic [29:0] a, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input int exp_lat);
        cpu_exp_t e;
        int n;
        e.is_read = rd && !wr; e.rdata = exp_rd; e.lat = exp_lat;
        cpu_q.push_back(e);
        @(posedge clk); #1;
        proc_read = rd; proc_write = wr; proc_addr = a; proc_wdata = wd; issue_cyc = cyc;
        n = 0;
        @(negedge clk);
        while (proc_stall && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (proc_stall) begin
            checks++; errors++;
            $display("FAIL access_timeout: addr %0h actual stalled required completion", a);
        end
        @(posedge clk); #1;
        proc_read = 1'b0; proc_write = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual no finish required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        proc_reset = 1'b1; proc_read = 1'b0; proc_write = 1'b0;
        proc_addr = '0; proc_wdata = '0; spur_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 proc_reset = 1'b0;
        @(negedge clk);
        check("rst_stall", 128'(proc_stall), 128'd0);
        check("rst_rdata", 128'(proc_rdata), 128'd0);
        check("rst_mem_read", 128'(mem_read), 128'd0);
        check("rst_mem_write", 128'(mem_write), 128'd0);
        check("rst_mem_addr", 128'(mem_addr), 128'd0);
        check("rst_mem_wdata", mem_wdata, 128'd0);

        expect_mem(1'b0, 28'h1, '0);
        access(1'b1, 1'b0, 30'h5, '0, 32'hB, 2);
        access(1'b1, 1'b0, 30'h5, '0, 32'hB, 0);
`ifdef DCACHE_WRITE_BACK_EN
        access(1'b0, 1'b1, 30'h4, 32'hCAFE, '0, 0);
        expect_mem(1'b0, 28'h5, '0);
        access(1'b1, 1'b0, 30'h14, '0, 32'h1000_0050, 2);
        access(1'b1, 1'b0, 30'h4, '0, 32'hCAFE, 0);
        expect_mem(1'b0, 28'h9, '0);
        access(1'b1, 1'b0, 30'h24, '0, 32'h1000_0090, 2);
        expect_mem(1'b1, 28'h1, {32'hD, 32'hC, 32'hB, 32'hCAFE});
        expect_mem(1'b0, 28'h5, '0);
        access(1'b1, 1'b0, 30'h14, '0, 32'h1000_0050, 4);
        access(1'b1, 1'b0, 30'h26, '0, 32'h1000_0092, 0);
        expect_mem(1'b0, 28'hC, '0);
        access(1'b0, 1'b1, 30'h30, 32'h1234_5678, '0, 2);
        access(1'b1, 1'b0, 30'h30, '0, 32'h1234_5678, 0);
        access(1'b1, 1'b1, 30'h31, 32'hBEEF, '0, 0);
`else
        expect_mem(1'b1, 28'h1, {32'hD, 32'hC, 32'hB, 32'hCAFE});
        access(1'b0, 1'b1, 30'h4, 32'hCAFE, '0, 2);
        access(1'b1, 1'b0, 30'h4, '0, 32'hCAFE, 0);
        expect_mem(1'b0, 28'h5, '0);
        access(1'b1, 1'b0, 30'h14, '0, 32'h1000_0050, 2);
        access(1'b1, 1'b0, 30'h4, '0, 32'hCAFE, 0);
        expect_mem(1'b0, 28'h9, '0);
        access(1'b1, 1'b0, 30'h24, '0, 32'h1000_0090, 2);
        expect_mem(1'b0, 28'h5, '0);
        access(1'b1, 1'b0, 30'h15, '0, 32'h1000_0051, 2);
        access(1'b1, 1'b0, 30'h26, '0, 32'h1000_0092, 0);
        expect_mem(1'b0, 28'hC, '0);
        expect_mem(1'b1, 28'hC, {32'h1000_00C3, 32'h1000_00C2, 32'h1000_00C1, 32'h1234_5678});
        access(1'b0, 1'b1, 30'h30, 32'h1234_5678, '0, 4);
        access(1'b1, 1'b0, 30'h30, '0, 32'h1234_5678, 0);
        expect_mem(1'b1, 28'hC, {32'h1000_00C3, 32'h1000_00C2, 32'h0000_BEEF, 32'h1234_5678});
        access(1'b1, 1'b1, 30'h31, 32'hBEEF, '0, 2);
`endif
        access(1'b1, 1'b0, 30'h31, '0, 32'hBEEF, 0);

        hold_ready = 1'b1;
        @(posedge clk); #1;
        proc_read = 1'b1; proc_addr = 30'h40;
        @(negedge clk);
        check("miss_stall_same_cycle", 128'(proc_stall), 128'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("alloc_mem_read", 128'(mem_read), 128'd1);
        check("alloc_mem_addr", 128'(mem_addr), 128'h10);
        @(posedge clk); #1;
        proc_reset = 1'b1; proc_read = 1'b0;
        @(posedge clk); #1;
        proc_reset = 1'b0; hold_ready = 1'b0;
        @(negedge clk);
        check("abort_mem_read", 128'(mem_read), 128'd0);
        check("abort_mem_write", 128'(mem_write), 128'd0);
        check("abort_stall", 128'(proc_stall), 128'd0);
        expect_mem(1'b0, 28'h10, '0);
        access(1'b1, 1'b0, 30'h40, '0, 32'h1000_0100, 2);
        expect_mem(1'b0, 28'hC, '0);
        access(1'b1, 1'b0, 30'h31, '0, 32'h1000_00C1, 2);

        @(posedge clk); #1;
        spur_ready = 1'b1;
        @(negedge clk);
        check("idle_ready_stall", 128'(proc_stall), 128'd0);
        check("idle_ready_mem", 128'({mem_read, mem_write}), 128'd0);
        check("idle_ready_rdata", 128'(proc_rdata), 128'd0);
        @(posedge clk); #1;
        spur_ready = 1'b0;
        access(1'b1, 1'b0, 30'h40, '0, 32'h1000_0100, 0);

        repeat (3) @(posedge clk);
        check("cpu_queue_drained", 128'(cpu_q.size()), 128'd0);
        check("mem_queue_drained", 128'(mem_q.size()), 128'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dcache_assoc.md
DCACHE_ASSOC -- requirements
Module: dcache_assoc

Interface
REQ-001 Parameter SETS, default 4, number of sets; power of two, 2..256; IDX_W = log2(SETS), TAG_W = 28-IDX_W.
REQ-002 Parameter WAYS, fixed at 2, associativity; any other value is illegal and is rejected at elaboration.
REQ-003 clk  input  1  single clock, all state updates on the rising edge.
REQ-004 proc_reset  input  1  synchronous, active-high reset.
REQ-005 proc_read  input  1  read request, held until proc_stall is low.
REQ-006 proc_write  input  1  write request, held until proc_stall is low.
REQ-007 proc_addr  input  30  word address: [1:0] word offset, [IDX_W+1:2] set index, [29:IDX_W+2] tag.
REQ-008 proc_wdata  input  32  write data.
REQ-009 proc_stall  output  1  request not yet complete.
REQ-010 proc_rdata  output  32  read data, valid when proc_read=1 and proc_stall=0.
REQ-011 mem_read  output  1  line read request.
REQ-012 mem_write  output  1  line write request.
REQ-013 mem_addr  output  28  line address {tag,index}.
REQ-014 mem_rdata  input  128  line read data, word n at [32n+31:32n].
REQ-015 mem_ready  input  1  one-cycle completion pulse for the current mem_read or mem_write.

Function
REQ-016 Storage per way per set: 128-bit data, TAG_W tag, valid bit, dirty bit (dirty only with CONFIG); one LRU bit per set naming the least-recently-used way.
REQ-017 FSM states: IDLE, WRITEBACK, ALLOCATE, WRITETHRU; reset state IDLE.
REQ-018 Read hit in IDLE: proc_stall=0, proc_rdata = selected word, combinational in the same cycle, zero added latency.
REQ-019 Miss in IDLE: proc_stall=1 in the same cycle; victim = invalid way 0, else invalid way 1, else the LRU way.
REQ-020 Miss with a valid and dirty victim: go to WRITEBACK; mem_write=1, mem_addr={victim tag,index}, mem_wdata = victim line until mem_ready; then go to ALLOCATE.
REQ-021 Miss with a clean or invalid victim: go directly to ALLOCATE.
REQ-022 ALLOCATE: mem_read=1, mem_addr=proc_addr[29:2] until mem_ready; on the mem_ready cycle the victim gets mem_rdata, the new tag and valid=1.
REQ-023 ALLOCATE on the mem_ready cycle of a read miss: proc_stall=0, proc_rdata = word from mem_rdata, next state IDLE.
REQ-024 ALLOCATE on the mem_ready cycle of a write miss: proc_wdata is merged into the filled line; dirty=1, proc_stall=0, next state IDLE (WRITETHRU without CONFIG).
REQ-025 Every hit and every fill sets the set's LRU bit to the other way.
REQ-026 mem_read and mem_write are never high together; mem_addr and mem_wdata are 0 whenever both are low.
REQ-027 proc_read and proc_write both high is treated as a write.
REQ-028 With no request in IDLE, all outputs are 0.
REQ-029 mem_ready is ignored in IDLE.

Reset
REQ-030 On a clk edge with proc_reset=1: state IDLE; all valid, dirty and LRU bits cleared; data and tags zeroed.
REQ-031 Reset mid-WRITEBACK or mid-ALLOCATE abandons the transaction; mem_read and mem_write are 0 from the next cycle.
REQ-032 Output values after reset: proc_stall=0, proc_rdata=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0.

Configuration
REQ-033 Macro DCACHE_WRITE_BACK_EN defined: write-back policy with dirty bits. A write hit updates the word, sets dirty, proc_stall=0, and generates no memory traffic; WRITETHRU is unreachable.
REQ-034 Macro DCACHE_WRITE_BACK_EN undefined: write-through policy with no dirty bits, and WRITEBACK is unreachable. A write hit updates the word, proc_stall=1, and enters WRITETHRU. WRITETHRU drives mem_write=1 with the merged line and mem_addr=proc_addr[29:2]; on mem_ready it sets proc_stall=0 and returns to IDLE.

Verification (SETS=4)
REQ-035 Cold read: reset, then read 30'h5 -> mem_read=1, mem_addr=28'h1; mem_ready with mem_rdata=128'hD_C_B_A (words) -> proc_rdata=32'hB, proc_stall=0 in that cycle.
REQ-036 Read hit: repeat read 30'h5 -> proc_stall=0 in the same cycle, proc_rdata=32'hB, mem_read stays 0.
REQ-037 LRU: (WB) write 30'h4, read 30'h14, read 30'h4, read 30'h24 -> line 28'h5 is evicted clean (no mem_write); then read 30'h14 -> mem_write with mem_addr=28'h1 carrying the written word, followed by mem_read with mem_addr=28'h5.
REQ-038 Write-through (macro off): write hit to 30'h4 with data 32'hCAFE -> mem_write=1, mem_wdata[31:0]=32'hCAFE, proc_stall=1 until mem_ready.
REQ-039 Reset during ALLOCATE (mem_ready withheld) -> next cycle mem_read=0 and proc_stall=0; a re-read of the same address misses.
